// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - shares one sram-like port between instruction and data requesters
module sram_req_arbiter #(
  parameter int MAX_OUTST  = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  // owner FIFO: bit value 0 = inst, 1 = data, in issue order
  logic [MAX_OUTST-1:0] owner_q;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [STV_W-1:0]     starve_cnt;

  logic full;
  logic starved;
  logic grant_data;
  logic grant_inst;
  logic push;
  logic pop;
  logic head_owner;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Outputs are forced low while reset is held so nothing leaks out during reset.
  assign full       = (count == CNT_W'(MAX_OUTST));
  assign starved    = inst_req && (starve_cnt == STV_W'(STARVE_MAX));
  assign grant_data = resetn && !full && data_req && !starved;
  assign grant_inst = resetn && !full && inst_req && !grant_data;
  assign push       = (grant_data || grant_inst) && mem_addr_ok;
  assign pop        = resetn && mem_data_ok && (count != '0);
  assign head_owner = owner_q[rd_ptr];

  assign inst_addr_ok = grant_inst && mem_addr_ok;
  assign data_addr_ok = grant_data && mem_addr_ok;
  assign inst_data_ok = pop && !head_owner;
  assign data_data_ok = pop && head_owner;
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;

  // Mirror the granted requester onto the shared port; idle port drives zeros.
  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_data) begin
      mem_req   = 1'b1;
      mem_wr    = data_wr;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else if (grant_inst) begin
      mem_req   = 1'b1;
      mem_addr  = inst_addr;
    end
  end

  // Owner FIFO bookkeeping; push and pop in the same cycle leave count unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        owner_q[wr_ptr] <= grant_data;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Count consecutive cycles inst waits while data is accepted, saturating at the limit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (!inst_req || inst_addr_ok) begin
      starve_cnt <= '0;
    end else if (data_addr_ok && (starve_cnt != STV_W'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - directed scoreboard bench for sram_req_arbiter
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;
  logic sb_owner[$];

  sram_req_arbiter #(.MAX_OUTST(2), .STARVE_MAX(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                       input logic dwr, input logic [3:0] dstrb, input logic [31:0] daddr,
                       input logic [31:0] dwdata, input logic aok, input logic dok,
                       input logic [31:0] rdat);
    inst_req    = ireq;
    inst_addr   = iaddr;
    data_req    = dreq;
    data_wr     = dwr;
    data_wstrb  = dstrb;
    data_addr   = daddr;
    data_wdata  = dwdata;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rdat;
  endtask

  task automatic drive_idle(input logic dok, input logic [31:0] rdat);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, dok, rdat);
  endtask

  // Called at a negedge with inputs already driven: check one cycle, then advance.
  task automatic cyc(input string tag, input logic exp_req, input logic exp_own);
    logic o;
    #1;
    chk({tag, ".mem_req"}, 32'(mem_req), 32'(exp_req));
    chk({tag, ".inst_addr_ok"}, 32'(inst_addr_ok), 32'(exp_req && !exp_own && mem_addr_ok));
    chk({tag, ".data_addr_ok"}, 32'(data_addr_ok), 32'(exp_req && exp_own && mem_addr_ok));
    if (exp_req) begin
      chk({tag, ".mem_addr"}, mem_addr, exp_own ? data_addr : inst_addr);
      chk({tag, ".mem_wr"}, 32'(mem_wr), exp_own ? 32'(data_wr) : 32'd0);
      chk({tag, ".mem_wstrb"}, 32'(mem_wstrb), exp_own ? 32'(data_wstrb) : 32'd0);
      chk({tag, ".mem_wdata"}, mem_wdata, exp_own ? data_wdata : 32'd0);
    end
    if (mem_data_ok && sb_owner.size() > 0) begin
      o = sb_owner.pop_front();
      chk({tag, ".inst_data_ok"}, 32'(inst_data_ok), 32'(!o));
      chk({tag, ".data_data_ok"}, 32'(data_data_ok), 32'(o));
      chk({tag, ".inst_rdata"}, inst_rdata, o ? 32'd0 : mem_rdata);
      chk({tag, ".data_rdata"}, data_rdata, o ? mem_rdata : 32'd0);
    end else begin
      chk({tag, ".inst_data_ok_idle"}, 32'(inst_data_ok), 32'd0);
      chk({tag, ".data_data_ok_idle"}, 32'(data_data_ok), 32'd0);
    end
    if (exp_req && mem_addr_ok) sb_owner.push_back(exp_own);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, ".mem_addr"}, mem_addr, 32'd0);
    chk({tag, ".addr_ok"}, 32'({inst_addr_ok, data_addr_ok}), 32'd0);
    chk({tag, ".data_ok"}, 32'({inst_data_ok, data_data_ok}), 32'd0);
    chk({tag, ".rdata"}, inst_rdata | data_rdata, 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    drive(1'b1, 32'h1c000000, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b1, 1'b1, 32'hdead);
    @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    drive_idle(1'b0, 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // store path
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h200, 32'h12345678, 1'b1, 1'b0, 32'h0);
    cyc("store", 1'b1, 1'b1);
    drive_idle(1'b1, 32'h0);
    cyc("store_ack", 1'b0, 1'b0);

    // fill to MAX_OUTST, then full blocks grant; simultaneous pop does not unblock same cycle
    drive(1'b1, 32'h1c000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc("mo_inst", 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hf, 32'h100, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc("mo_data", 1'b1, 1'b1);
    drive(1'b1, 32'h1c000000, 1'b1, 1'b0, 4'hf, 32'h100, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc("mo_full", 1'b0, 1'b0);
    drive(1'b1, 32'h1c000000, 1'b1, 1'b0, 4'hf, 32'h100, 32'h0, 1'b1, 1'b1, 32'h0000000a);
    cyc("full_pop", 1'b0, 1'b0);
    drive(1'b1, 32'h1c000000, 1'b1, 1'b0, 4'hf, 32'h100, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc("after_pop", 1'b1, 1'b1);
    drive_idle(1'b1, 32'h000000b1);
    cyc("drain0", 1'b0, 1'b0);
    drive_idle(1'b1, 32'h000000b2);
    cyc("drain1", 1'b0, 1'b0);

    // interleaved owners: inst, data, inst -> 0xA, 0xB, 0xC
    drive(1'b1, 32'h1c000010, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc("ooo_i0", 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hf, 32'h300, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc("ooo_d", 1'b1, 1'b1);
    drive_idle(1'b1, 32'h0000000a);
    cyc("ooo_ra", 1'b0, 1'b0);
    drive(1'b1, 32'h1c000020, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0000000b);
    cyc("ooo_i1_rb", 1'b1, 1'b0);
    drive_idle(1'b1, 32'h0000000c);
    cyc("ooo_rc", 1'b0, 1'b0);

    // mem_data_ok with empty FIFO is ignored
    drive_idle(1'b1, 32'h55);
    cyc("empty_dok", 1'b0, 1'b0);

    // starvation: data wins 4 cycles, inst forced on the 5th, data again after
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h1c000040 + 32'(i), 1'b1, 1'b0, 4'hf, 32'h400 + 32'(i), 32'h0,
            1'b1, 1'b1, 32'h100 + 32'(i));
      cyc($sformatf("starve%0d", i), 1'b1, (i == 4) ? 1'b0 : 1'b1);
    end
    drive_idle(1'b1, 32'h1ff);
    cyc("starve_drain", 1'b0, 1'b0);

    // reset mid-flight with two outstanding
    drive(1'b1, 32'h1c000080, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc("rst_i", 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hf, 32'h500, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc("rst_d", 1'b1, 1'b1);
    drive(1'b1, 32'h1c000084, 1'b1, 1'b0, 4'hf, 32'h504, 32'h0, 1'b1, 1'b1, 32'h77);
    #2 resetn = 1'b0;
    #1;
    chk_all_zero("midreset");
    sb_owner.delete();
    @(negedge clk);
    drive_idle(1'b0, 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    drive_idle(1'b1, 32'h66);
    cyc("post_rst_dok", 1'b0, 1'b0);
    drive(1'b1, 32'h1c000090, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc("post_rst_i0", 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hf, 32'h600, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc("post_rst_d", 1'b1, 1'b1);
    drive_idle(1'b1, 32'h99);
    cyc("post_rst_r0", 1'b0, 1'b0);
    drive_idle(1'b1, 32'h9a);
    cyc("post_rst_r1", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
